// File: rtl/vmem_disp_scan_pkg.sv
// Shared constants, pipeline control struct and helpers for the VMEM display scan-out.
// Framebuffer geometry defaults describe a 160x120 buffer shown 4x upscaled on 640x480.
package vmem_disp_scan_pkg;

    localparam int DEF_VMEM_ADDRW  = 15;
    localparam int DEF_VMEM_WDATAW = 3;
    localparam int DEF_FB_WIDTH    = 160;
    localparam int DEF_FB_HEIGHT   = 120;
    localparam int DEF_SCALE       = 4;
    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;

    // Logical (polarity-free) control bits that travel alongside pixel data.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } scan_ctl_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [11:0] rgb_expand(input logic [2:0] px);
        return {{4{px[2]}}, {4{px[1]}}, {4{px[0]}}};
    endfunction

endpackage

// File: rtl/vmem_disp_scan_if.sv
// VMEM read port between the scan-out stage (master) and the video memory (slave).
// Read data is expected to be valid before the clock edge following the address.
interface vmem_disp_scan_if #(
    parameter int ADDRW = 15,
    parameter int DATAW = 3
);
    logic [ADDRW-1:0] disp_raddr;
    logic [DATAW-1:0] disp_rdata;

    modport master (output disp_raddr, input  disp_rdata);
    modport slave  (input  disp_raddr, output disp_rdata);
endinterface

// File: rtl/disp_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical raster counters and sync/active decode.
// Decode outputs are combinational from the counters; consumers register them.
module disp_timing_gen
    import vmem_disp_scan_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HCW      = cw(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VCW      = cw(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    output logic           tick,
    output logic [HCW-1:0] h_cnt,
    output logic [VCW-1:0] v_cnt,
    output logic           active,
    output logic           hs,
    output logic           vs
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = cw(CLK_DIV);

    localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT   = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_BEG  = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END  = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_ACT   = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] VS_BEG  = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END  = VCW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_q;

    assign tick = (div_q == DIV_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

endmodule

// File: rtl/vmem_disp_scan.sv
// Display scan-out: incremental framebuffer address generation feeding a 2-tick pipeline
// (address stage, then data/sync stage) so RGB, DE and syncs leave mutually aligned.
module vmem_disp_scan
    import vmem_disp_scan_pkg::*;
#(
    parameter int VMEM_ADDRW  = DEF_VMEM_ADDRW,
    parameter int VMEM_WDATAW = DEF_VMEM_WDATAW,
    parameter int FB_WIDTH    = DEF_FB_WIDTH,
    parameter int FB_HEIGHT   = DEF_FB_HEIGHT,
    parameter int SCALE       = DEF_SCALE,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    vmem_disp_scan_if.master        vmem,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    de_o,
    output logic [11:0]             rgb_o,
    output logic                    frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = cw(H_TOTAL);
    localparam int VCW     = cw(V_TOTAL);
    localparam int SW      = cw(SCALE);
    localparam int FXW     = cw(H_ACTIVE + FB_WIDTH + 1);
    localparam int FYW     = cw(V_ACTIVE + FB_HEIGHT + 1);

    localparam logic [HCW-1:0]        H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0]        H_ACT    = HCW'(H_ACTIVE);
    localparam logic [VCW-1:0]        V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0]        V_ACT    = VCW'(V_ACTIVE);
    localparam logic [SW-1:0]         S_MAX    = SW'(SCALE - 1);
    localparam logic [FXW-1:0]        FBW_L    = FXW'(FB_WIDTH);
    localparam logic [FYW-1:0]        FBH_L    = FYW'(FB_HEIGHT);
    localparam logic [VMEM_ADDRW-1:0] ROW_STEP = VMEM_ADDRW'(FB_WIDTH);

    logic           tick, active, hs, vs;
    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;

    disp_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HCW     (HCW),
        .VCW     (VCW)
    ) u_timing (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick  (tick),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .active(active),
        .hs    (hs),
        .vs    (vs)
    );

    logic                  h_last, v_last, h_act, v_act, in_fb;
    logic [SW-1:0]         sx, sy;
    logic [FXW-1:0]        fb_x;
    logic [FYW-1:0]        fb_y;
    logic [VMEM_ADDRW-1:0] row_base, addr_nxt;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign h_act  = (h_cnt < H_ACT);
    assign v_act  = (v_cnt < V_ACT);
    assign in_fb  = (fb_x < FBW_L) && (fb_y < FBH_L);

    // Pixels outside the upscaled framebuffer but inside the active window read address 0.
    assign addr_nxt = (active && in_fb) ? row_base + VMEM_ADDRW'(fb_x) : '0;

    // Sub-pixel counters track the raster counters one-for-one, so no divide is needed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sx       <= '0;
            sy       <= '0;
            fb_x     <= '0;
            fb_y     <= '0;
            row_base <= '0;
        end else if (tick) begin
            if (h_last) begin
                sx   <= '0;
                fb_x <= '0;
                if (v_last) begin
                    sy       <= '0;
                    fb_y     <= '0;
                    row_base <= '0;
                end else if (v_act) begin
                    if (sy == S_MAX) begin
                        sy       <= '0;
                        fb_y     <= fb_y + 1'b1;
                        row_base <= row_base + ROW_STEP;
                    end else begin
                        sy <= sy + 1'b1;
                    end
                end
            end else if (h_act) begin
                if (sx == S_MAX) begin
                    sx   <= '0;
                    fb_x <= fb_x + 1'b1;
                end else begin
                    sx <= sx + 1'b1;
                end
            end
        end
    end

    scan_ctl_t             ctl_s1, ctl_s2;
    logic                  first_s1;
    logic [VMEM_ADDRW-1:0] raddr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            raddr_q  <= '0;
            ctl_s1   <= '0;
            first_s1 <= 1'b0;
        end else if (tick) begin
            raddr_q  <= addr_nxt;
            ctl_s1   <= '{de: active, hs: hs, vs: vs};
            first_s1 <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign vmem.disp_raddr = raddr_q;

    // Read data for raddr_q settles one clk after the address, i.e. by the next tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctl_s2        <= '0;
            rgb_o         <= '0;
            frame_start_o <= 1'b0;
        end else begin
            frame_start_o <= tick & first_s1;
            if (tick) begin
                ctl_s2 <= ctl_s1;
                rgb_o  <= (ctl_s1.de && enable_i) ? rgb_expand(vmem.disp_rdata[2:0]) : '0;
            end
        end
    end

    assign de_o    = ctl_s2.de;
    assign hsync_o = ctl_s2.hs ? SYNC_POL : ~SYNC_POL;
    assign vsync_o = ctl_s2.vs ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vmem_disp_scan.sv
// Two scan-out instances (tick every clk / every 4 clks, different framebuffer bounds)
// compared cycle by cycle against a raster-index reference model.
module tb_vmem_disp_scan;
    localparam int HA = 8, HFP = 2, HSY = 3, HBP = 1, HT = HA + HFP + HSY + HBP;
    localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1, VT = VA + VFP + VSY + VBP;
    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  mem [16];

    logic        hs1, vs1, de1, fs1, hs4, vs4, de4, fs4;
    logic [11:0] rgb1, rgb4;

    int n_tot = 0;
    int n_bad = 0;
    int e     = 0;
    logic en1, en4;

    always #5 clk = ~clk;

    vmem_disp_scan_if #(.ADDRW(4), .DATAW(3)) vif1 ();
    vmem_disp_scan_if #(.ADDRW(4), .DATAW(3)) vif4 ();

    assign vif1.disp_rdata = mem[vif1.disp_raddr];
    assign vif4.disp_rdata = mem[vif4.disp_raddr];

    vmem_disp_scan #(
        .VMEM_ADDRW(4), .VMEM_WDATAW(3), .FB_WIDTH(4), .FB_HEIGHT(2), .SCALE(SC), .CLK_DIV(1),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .vmem(vif1),
        .hsync_o(hs1), .vsync_o(vs1), .de_o(de1), .rgb_o(rgb1), .frame_start_o(fs1)
    );

    vmem_disp_scan #(
        .VMEM_ADDRW(4), .VMEM_WDATAW(3), .FB_WIDTH(3), .FB_HEIGHT(1), .SCALE(SC), .CLK_DIV(4),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b1)
    ) dut4 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .vmem(vif4),
        .hsync_o(hs4), .vsync_o(vs4), .de_o(de4), .rgb_o(rgb4), .frame_start_o(fs4)
    );

    typedef struct packed {
        logic        de, hs, vs, fs;
        logic [11:0] rgb;
        logic [31:0] raddr;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    // Framebuffer address of raster pixel number p counted from the start of scan.
    function automatic logic [31:0] pix_addr(input int p, input int fbw, input int fbh);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < HA && v < VA && h / SC < fbw && v / SC < fbh)
            return 32'((v / SC) * fbw + h / SC);
        return 32'd0;
    endfunction

    // After edge e, k ticks have happened; outputs show pixel k-2, the address pixel k-1.
    function automatic exp_t model(input int edges, input int d, input int fbw, input int fbh,
                                   input logic pol, input logic en);
        exp_t x;
        int k, p, h, v;
        logic [2:0] px;
        x = '0;
        x.hs = ~pol;
        x.vs = ~pol;
        k = edges / d;
        if (k >= 1) x.raddr = pix_addr(k - 1, fbw, fbh);
        if (k >= 2) begin
            p = k - 2;
            h = p % HT;
            v = (p / HT) % VT;
            x.de = (h < HA) && (v < VA);
            x.hs = (h >= HA + HFP && h < HA + HFP + HSY) ? pol : ~pol;
            x.vs = (v >= VA + VFP && v < VA + VFP + VSY) ? pol : ~pol;
            px   = mem[pix_addr(p, fbw, fbh)];
            if (x.de && en) x.rgb = {{4{px[2]}}, {4{px[1]}}, {4{px[0]}}};
            x.fs = (edges % d == 0) && (p % (HT * VT) == 0);
        end
        return x;
    endfunction

    task automatic chk_all(input int edges);
        exp_t x;
        x = model(edges, 1, 4, 2, 1'b0, en1);
        chk("d1_de",    de1,  x.de);
        chk("d1_hsync", hs1,  x.hs);
        chk("d1_vsync", vs1,  x.vs);
        chk("d1_fs",    fs1,  x.fs);
        chk("d1_rgb",   rgb1, x.rgb);
        chk("d1_raddr", vif1.disp_raddr, x.raddr);
        x = model(edges, 4, 3, 1, 1'b1, en4);
        chk("d4_de",    de4,  x.de);
        chk("d4_hsync", hs4,  x.hs);
        chk("d4_vsync", vs4,  x.vs);
        chk("d4_fs",    fs4,  x.fs);
        chk("d4_rgb",   rgb4, x.rgb);
        chk("d4_raddr", vif4.disp_raddr, x.raddr);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            e++;
            if (e % 4 == 0) en4 = enable;
            en1 = enable;
            @(negedge clk);
            chk_all(e);
            if ($urandom_range(0, 29) == 0) enable = ~enable;
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        en1    = 1'b1;
        en4    = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 3'(i);
        mem[0] = 3'b101;
        repeat (2) @(negedge clk);
        chk_all(0);
        rst = 1'b0;
        e   = 0;
        run(1300);

        // Asynchronous reset mid-frame, between clock edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all(0);
        for (int i = 0; i < 16; i++) mem[i] = 3'($urandom_range(0, 7));
        @(negedge clk);
        @(negedge clk);
        chk_all(0);
        rst = 1'b0;
        e   = 0;
        run(700);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
